// File: rtl/memory_ctrl_pkg.sv
// Shared types and constants for the fixed-latency memory controller.
// State encodings, default parameters and the captured request layout.
package memory_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int LATENCY_DEF    = 5;
    localparam int DEPTH_LOG2_DEF = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic DS_WORD  = 1'b1;
    localparam logic DS_BYTE  = 1'b0;

    typedef struct packed {
        logic        rw;
        logic        datasize;
        logic [15:0] mar;
        logic [15:0] mdr;
    } req_t;

endpackage

// File: rtl/memory_ctrl_mem_array.sv
// 16-bit synchronous RAM with per-byte write enables and a registered read port.
// No reset: contents and read register survive controller resets.
module mem_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [1:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    input  logic                  re,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (re)    rdata           <= mem[addr];
    end

endmodule

// File: rtl/memory_ctrl.sv
// Fixed-latency memory controller: captures a request, waits LATENCY cycles,
// commits the write or read on the edge entering READY and pulses R for one cycle.
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEMEN,
    input  logic        RW,
    input  logic        DATASIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic        R,
    output logic [15:0] MEMDATA
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    req_t                  req, req_eff;
    logic                  capture, commit, re, rd_valid;
    logic [1:0]            we;
    logic [DEPTH_LOG2-1:0] addr;
    logic [15:0]           rdata;

    assign capture = (state == ST_IDLE) && MEMEN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (MEMEN) state_nxt = (LATENCY == 1) ? ST_READY : ST_WAIT;
            ST_WAIT:  if (cnt <= 4'd1) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the capture edge is also the commit edge, so the live
    // inputs stand in for the request registers while still in IDLE.
    always_comb begin
        req_eff = req;
        if (state == ST_IDLE) req_eff = '{rw: RW, datasize: DATASIZE, mar: MAR, mdr: MDR};
    end

    always_comb begin
        R      = (state == ST_READY);
        commit = reset && (state != ST_READY) && (state_nxt == ST_READY);
        we[0]  = commit && req_eff.rw && (req_eff.datasize || !req_eff.mar[0]);
        we[1]  = commit && req_eff.rw && (req_eff.datasize ||  req_eff.mar[0]);
        re     = commit && !req_eff.rw;
        addr   = req_eff.mar[DEPTH_LOG2:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            req <= '0;
        end else begin
            if (capture)               cnt <= CNT_LOAD;
            else if (state == ST_WAIT) cnt <= cnt - 4'd1;
            if (capture) req <= '{rw: RW, datasize: DATASIZE, mar: MAR, mdr: MDR};
        end
    end

    // RAM read register has no reset; this flag makes MEMDATA read zero until
    // the first read after reset completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rd_valid <= 1'b0;
        else if (re) rd_valid <= 1'b1;
    end

    assign MEMDATA = rd_valid ? rdata : 16'h0000;

    generate
        if (DEPTH_LOG2 < 15) begin : g_unused
            logic unused_mar_hi;
            assign unused_mar_hi = ^req_eff.mar[15:DEPTH_LOG2+1];
        end
    endgenerate

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (req_eff.mdr),
        .re    (re),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_memory_ctrl.sv
// Self-checking bench for memory_ctrl: directed scenarios plus randomized
// accesses against a word-array reference model.
module tb_memory_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, memen, rw, ds, r;
    logic [15:0] mar, mdr, memdata;
    logic        reset1, memen1, rw1, ds1, r1;
    logic [15:0] mar1, mdr1, memdata1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_memdata;

    memory_ctrl #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .clk(clk), .reset(reset), .MEMEN(memen), .RW(rw), .DATASIZE(ds),
        .MAR(mar), .MDR(mdr), .R(r), .MEMDATA(memdata)
    );

    memory_ctrl #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .reset(reset1), .MEMEN(memen1), .RW(rw1), .DATASIZE(ds1),
        .MAR(mar1), .MDR(mdr1), .R(r1), .MEMDATA(memdata1)
    );

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / 2) % 256;
    endfunction

    function automatic void model_access(input bit w, input bit size,
                                         input logic [15:0] a, input logic [15:0] d);
        int i;
        i = word_of(a);
        if (w) begin
            if (size)           ref_mem[i] = d;
            else if (a % 2 == 1) ref_mem[i] = {d[15:8], ref_mem[i][7:0]};
            else                 ref_mem[i] = {ref_mem[i][15:8], d[7:0]};
        end else begin
            ref_memdata = ref_mem[i];
        end
    endfunction

    task automatic access(input bit w, input bit size, input logic [15:0] a,
                          input logic [15:0] d, input bit scramble, input string name);
        int first, highs;
        logic [15:0] md_at_r;
        @(negedge clk);
        memen = 1'b1; rw = w; ds = size; mar = a; mdr = d;
        @(posedge clk);
        #1;
        memen = 1'b0;
        if (scramble) begin
            rw  = 1'($urandom);
            ds  = 1'($urandom);
            mar = 16'($urandom);
            mdr = 16'($urandom);
        end
        model_access(w, size, a, d);
        first = 0; highs = 0; md_at_r = 'x;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (r === 1'b1) begin
                highs++;
                if (first == 0) begin
                    first   = k;
                    md_at_r = memdata;
                end
            end
        end
        checks++;
        if (first !== LAT || highs !== 1) begin
            failures++;
            $display("FAIL %s r_timing: first_high=%0d highs=%0d required first_high=%0d highs=1",
                     name, first, highs, LAT);
        end
        checks++;
        if (md_at_r !== ref_memdata) begin
            failures++;
            $display("FAIL %s memdata: got %h required %h", name, md_at_r, ref_memdata);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; memen = 1'b0; rw = 1'b0; ds = 1'b0; mar = '0; mdr = '0;
        reset1 = 1'b0; memen1 = 1'b0; rw1 = 1'b0; ds1 = 1'b0; mar1 = '0; mdr1 = '0;
        ref_memdata = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (r !== 1'b0) begin failures++; $display("FAIL reset_r: got %b required 0", r); end
        checks++;
        if (memdata !== 16'h0000) begin
            failures++; $display("FAIL reset_memdata: got %h required 0000", memdata);
        end
        checks++;
        if (r1 !== 1'b0 || memdata1 !== 16'h0000) begin
            failures++; $display("FAIL reset_dut1: got r=%b memdata=%h required r=0 memdata=0000", r1, memdata1);
        end
        reset = 1'b1; reset1 = 1'b1;
    endtask

    task automatic test_word_rw;
        access(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "word_write");
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, "word_read");
    endtask

    task automatic test_byte_write;
        access(1'b1, 1'b0, 16'h0011, 16'h1234, 1'b0, "byte_write_hi");
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "byte_read_hi");
        access(1'b1, 1'b0, 16'h0010, 16'h56AB, 1'b0, "byte_write_lo");
        access(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, "byte_read_lo");
    endtask

    task automatic test_wrap;
        access(1'b1, 1'b1, 16'h0210, 16'h7E57, 1'b0, "wrap_write");
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, "wrap_read");
    endtask

    task automatic test_frozen;
        access(1'b1, 1'b1, 16'h0020, 16'hCAFE, 1'b1, "frozen_write");
        access(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, "frozen_read");
    endtask

    task automatic test_reset_abort;
        int highs;
        access(1'b1, 1'b1, 16'h0040, 16'hC0DE, 1'b0, "abort_seed");
        access(1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, "abort_seed_read");
        // read captured, reset lands mid-WAIT
        @(negedge clk);
        memen = 1'b1; rw = 1'b0; ds = 1'b1; mar = 16'h0040;
        @(posedge clk);
        #1 memen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        ref_memdata = 16'h0000;
        checks++;
        if (memdata !== 16'h0000 || r !== 1'b0) begin
            failures++;
            $display("FAIL abort_async_clear: got r=%b memdata=%h required r=0 memdata=0000", r, memdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        highs = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (r === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0 || memdata !== 16'h0000) begin
            failures++;
            $display("FAIL abort_read_dropped: got highs=%0d memdata=%h required highs=0 memdata=0000", highs, memdata);
        end
        // write captured, reset before commit
        @(negedge clk);
        memen = 1'b1; rw = 1'b1; ds = 1'b1; mar = 16'h0040; mdr = 16'hDEAD;
        @(posedge clk);
        #1 memen = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        access(1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, "abort_write_readback");
    endtask

    task automatic test_random;
        logic [15:0] a, d;
        int i;
        for (int n = 0; n < 8; n++) begin
            a = (16'($urandom) & 16'hFE00) | 16'(16'h0100 + 2 * n);
            access(1'b1, 1'b1, a, 16'($urandom), 1'b0, "rand_init");
        end
        for (int n = 0; n < 30; n++) begin
            i = $urandom_range(0, 7);
            a = (16'($urandom) & 16'hFE00) | 16'(16'h0100 + 2 * i) | 16'($urandom_range(0, 1));
            d = 16'($urandom);
            access(1'($urandom), 1'($urandom), a, d, 1'($urandom), "rand_op");
        end
    endtask

    task automatic test_lat1_back_to_back;
        logic [7:0] pattern;
        @(negedge clk);
        memen1 = 1'b1; rw1 = 1'b1; ds1 = 1'b1; mar1 = 16'h0004; mdr1 = 16'hA5C3;
        @(posedge clk);
        pattern = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pattern = {pattern[6:0], r1};
        end
        memen1 = 1'b0;
        checks++;
        if (pattern !== 8'b1010_1010) begin
            failures++; $display("FAIL lat1_pattern: got %b required 10101010", pattern);
        end
        @(negedge clk);
        memen1 = 1'b1; rw1 = 1'b0; mar1 = 16'h0004;
        @(posedge clk);
        #1 memen1 = 1'b0;
        @(negedge clk);
        checks++;
        if (r1 !== 1'b1 || memdata1 !== 16'hA5C3) begin
            failures++;
            $display("FAIL lat1_read: got r=%b memdata=%h required r=1 memdata=a5c3", r1, memdata1);
        end
        @(negedge clk);
        checks++;
        if (r1 !== 1'b0) begin failures++; $display("FAIL lat1_pulse_width: got r=%b required 0", r1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_wrap();
        test_frozen();
        test_reset_abort();
        test_random();
        test_lat1_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
